riscv_ahb_sram: RTL
===================

# riscv_ahb_sram

AHB-Lite responder backed by an internal word-addressed RAM; the slave-side counterpart of the core's instruction/data bus interface unit. It accepts single NONSEQ/SEQ transfers of byte, halfword and word size, performs them with a programmable number of wait states, and signals OKAY or, optionally, a two-cycle ERROR response. It sits behind the AHB decoder/arbiter as the boot/scratch memory for both the instruction and data masters.

## Interface
- XLEN, 32, data and address width; only 32 is supported.
- DEPTH, 1024, RAM size in 32-bit words; power of two.
- WAIT_STATES, 0, wait cycles inserted in every OKAY data phase; 0..15.

- hclk  in  1  bus clock, all state on rising edge
- hreset_n  in  1  asynchronous active-low reset
- hsel  in  1  slave select from decoder
- haddr  in  XLEN  byte address (address phase)
- htrans  in  2  0 IDLE, 1 BUSY, 2 NONSEQ, 3 SEQ
- hsize  in  3  0 byte, 1 half, 2 word
- hburst  in  3  ignored; every beat handled as a single transfer
- hprot  in  4  ignored
- hwrite  in  1  1 write, 0 read
- hwdata  in  XLEN  write data (data phase)
- hready  in  1  bus-level ready (from mux)
- hreadyout  out  1  slave ready
- hrdata  out  XLEN  read data
- hresp  out  2  0 OKAY, 1 ERROR

## Operation
- Accept: transfer is accepted at a rising edge when hsel & hready & htrans[1]. Capture haddr, hsize, hwrite into address registers. IDLE/BUSY or hsel=0 → zero-wait OKAY, nothing performed.
- States: S_IDLE, S_WAIT, S_DATA, S_ERR1, S_ERR2.
- S_IDLE: hreadyout=1, hresp=OKAY. On accept → S_WAIT if WAIT_STATES>0 (counter loaded with WAIT_STATES), else S_DATA; → S_ERR1 on an erroneous transfer (see Configuration).
- S_WAIT: hreadyout=0; counter decrements each cycle; at 1 → S_DATA.
- S_DATA: hreadyout=1, hresp=OKAY. Write: byte lanes selected from captured addr/size are written from hwdata at the edge ending this cycle. Read: hrdata valid. A new accept in this cycle (back-to-back) is processed exactly as from S_IDLE; otherwise → S_IDLE.
- Byte lanes, little-endian: byte → lane addr[1:0]; half → lanes {addr[1],0},{addr[1],1}; word → all four.
- RAM index = addr[clog2(DEPTH)+1:2]; upper bits ignored without the error feature (aliasing).
- Read data: hrdata loaded from RAM word at acceptance of a read (or at the last wait cycle), all 32 bits returned regardless of size; held until the next read loads. Read accepted in the same edge that completes a write to the same word returns the merged (newly written) bytes — write-to-read bypass is mandatory.
- Reset: state S_IDLE, hreadyout=1, hresp=OKAY, hrdata=0, counter=0, address registers 0. RAM contents are not cleared; reset mid-transfer abandons it with no RAM write.

## Timing
- Zero wait: read accepted at edge N → hrdata valid, hreadyout=1 in cycle N..N+1; write data sampled at edge N+1.
- WAIT_STATES=k: hreadyout low for exactly k cycles after acceptance, then high one cycle.
- Back-to-back transfers sustain one per cycle at k=0.
- ERROR: cycle 1 hreadyout=0/hresp=ERROR; cycle 2 hreadyout=1/hresp=ERROR; wait states not applied. A transfer accepted during cycle 2 is handled normally.
- hresp is OKAY in every cycle not in S_ERR1/S_ERR2.

## Configuration
- RISCV_AHB_SRAM_ERR_EN defined: accepted transfer with hsize>2, address not aligned to size, or haddr ≥ DEPTH*4 is not performed (no RAM write, hrdata unchanged) and receives the two-cycle ERROR response.
- Undefined: S_ERR1/S_ERR2 absent; hresp tied OKAY; hsize>2 treated as word; low address bits below size alignment ignored; out-of-range addresses alias.

## Test plan
- Reset with hreset_n low mid-wait → hreadyout=1, hresp=0, hrdata=0 asynchronously; prior RAM content preserved.
- WAIT_STATES=0: write word 0xDEADBEEF to 0x10, read 0x10 → 0xDEADBEEF, hreadyout never low.
- Byte write 0x5A to 0x13 over word 0x11223344 at 0x10, then read → 0x5A223344; half write 0xBEEF to 0x12 → 0xBEEF3344.
- Back-to-back write 0xCAFEF00D to 0x20 then read 0x20 in next address phase → hrdata 0xCAFEF00D (bypass).
- WAIT_STATES=3: read → hreadyout low exactly 3 cycles then high with correct data; IDLE htrans with hsel=1 → zero-wait OKAY.
- With RISCV_AHB_SRAM_ERR_EN: word read at 0x02 and word write at DEPTH*4 → two-cycle ERROR (0/ERROR then 1/ERROR), RAM unchanged; without macro same write aliases to word 0.

Source files
------------

// File: rtl/riscv_ahb_sram.sv
// riscv_ahb_sram: AHB-Lite responder over a word-addressed RAM with programmable wait states.
// Define RISCV_AHB_SRAM_ERR_EN for a two-cycle ERROR on bad size, misalignment or out-of-range address.
module riscv_ahb_sram #(
   parameter int XLEN        = 32,
   parameter int DEPTH       = 1024,
   parameter int WAIT_STATES = 0
) (
   input  logic            hclk,
   input  logic            hreset_n,
   input  logic            hsel,
   input  logic [XLEN-1:0] haddr,
   input  logic [1:0]      htrans,
   input  logic [2:0]      hsize,
   input  logic [2:0]      hburst,
   input  logic [3:0]      hprot,
   input  logic            hwrite,
   input  logic [XLEN-1:0] hwdata,
   input  logic            hready,
   output logic            hreadyout,
   output logic [XLEN-1:0] hrdata,
   output logic [1:0]      hresp
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [3:0] WS = 4'(WAIT_STATES);
`ifdef RISCV_AHB_SRAM_ERR_EN
   typedef enum logic [2:0] {S_IDLE, S_WAIT, S_DATA, S_ERR1, S_ERR2} state_t;
`else
   typedef enum logic [2:0] {S_IDLE, S_WAIT, S_DATA} state_t;
`endif
   state_t state, nxt, go;
   logic [XLEN-1:0] mem [DEPTH];
   logic [XLEN-1:0] a_addr, rd_word;
   logic [2:0] a_size;
   logic a_write, acc, err, wr, ld;
   logic [3:0] cnt, be;
   logic [AW-1:0] rd_idx, wr_idx;
   logic unused;
   assign unused = ^{hburst, hprot, haddr, a_addr, hsize};
   assign acc = hsel & hready & htrans[1] & hreadyout;
`ifdef RISCV_AHB_SRAM_ERR_EN
   assign err = (hsize > 3'd2) || (hsize == 3'd1 && haddr[0]) || (hsize == 3'd2 && haddr[1:0] != 2'b00)
              || (haddr[XLEN-1:AW+2] != '0);
   assign go = err ? S_ERR1 : (WS != 4'd0 ? S_WAIT : S_DATA);
   assign hreadyout = state != S_WAIT && state != S_ERR1;
   assign hresp = {1'b0, state == S_ERR1 || state == S_ERR2};
`else
   assign err = 1'b0;
   assign go = WS != 4'd0 ? S_WAIT : S_DATA;
   assign hreadyout = state != S_WAIT;
   assign hresp = 2'b00;
`endif
   assign be = a_size == 3'd0 ? 4'b0001 << a_addr[1:0] : a_size == 3'd1 ? (a_addr[1] ? 4'b1100 : 4'b0011) : 4'b1111;
   assign wr = state == S_DATA && a_write;
   assign wr_idx = a_addr[AW+1:2];
   assign rd_idx = state == S_WAIT ? a_addr[AW+1:2] : haddr[AW+1:2];
   assign ld = (acc && !hwrite && !err && WS == 4'd0) || (state == S_WAIT && cnt == 4'd1 && !a_write);
   // a read accepted while a write completes to the same word must see the new bytes
   always_comb begin
      rd_word = mem[rd_idx];
      for (int i = 0; i < 4; i++)
         if (wr && be[i] && rd_idx == wr_idx) rd_word[8*i +: 8] = hwdata[8*i +: 8];
   end
   always_comb begin
      nxt = acc ? go : S_IDLE;
      if (state == S_WAIT) nxt = cnt == 4'd1 ? S_DATA : S_WAIT;
`ifdef RISCV_AHB_SRAM_ERR_EN
      if (state == S_ERR1) nxt = S_ERR2;
`endif
   end
   always_ff @(posedge hclk or negedge hreset_n)
      if (!hreset_n) begin
         state   <= S_IDLE;
         cnt     <= '0;
         a_addr  <= '0;
         a_size  <= '0;
         a_write <= 1'b0;
         hrdata  <= '0;
      end else begin
         state <= nxt;
         cnt   <= acc ? WS : (state == S_WAIT ? cnt - 4'd1 : cnt);
         if (acc) begin
            a_addr  <= haddr;
            a_size  <= hsize;
            a_write <= hwrite;
         end
         if (ld) hrdata <= rd_word;
      end
   always_ff @(posedge hclk)
      if (wr)
         for (int i = 0; i < 4; i++)
            if (be[i]) mem[wr_idx][8*i +: 8] <= hwdata[8*i +: 8];
endmodule
